jb_rf_pa_switch_seq: RTL and testbench

Parametrised PA/antenna-switch sequencer driving the active-low RF front-end switch and PA-enable lines for `N_PA` channels. It enforces a programmable break-before-make delay between antenna-switch movement and PA enable on every RX↔TX transition. It also provides a register-driven override path. It sits between the control register file, which supplies delay, override and mask fields, and the RF board GPIO pins.

---
 rtl/jb_rf_pa_switch_seq_if.sv | 30 +++
 rtl/jb_rf_pa_switch_seq.sv | 134 +++++++++++++
 tb/tb_jb_rf_pa_switch_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/jb_rf_pa_switch_seq_if.sv
// Control/GPIO bundle between the register file (master) and the PA/antenna-switch sequencer (slave).
interface jb_rf_pa_switch_seq_if #(
  parameter int N_PA  = 6,
  parameter int DLY_W = 16
);
  logic             tx_req;
  logic [DLY_W-1:0] ant_switch_delay;
  logic [N_PA-1:0]  pa_chan_mask;
  logic             pa_switch_override;
  logic [N_PA-1:0]  pa_override_en_n;
  logic [N_PA-1:0]  pa_override_n;
  logic             err_clr;
  logic [N_PA-1:0]  pa_switch_en_n;
  logic [N_PA-1:0]  pa_switch_n;
  logic             tx_active;
  logic             busy;
  logic             seq_err;

  modport master (
    output tx_req, ant_switch_delay, pa_chan_mask, pa_switch_override,
           pa_override_en_n, pa_override_n, err_clr,
    input  pa_switch_en_n, pa_switch_n, tx_active, busy, seq_err
  );

  modport slave (
    input  tx_req, ant_switch_delay, pa_chan_mask, pa_switch_override,
           pa_override_en_n, pa_override_n, err_clr,
    output pa_switch_en_n, pa_switch_n, tx_active, busy, seq_err
  );
endinterface

// File: rtl/jb_rf_pa_switch_seq.sv
// Break-before-make PA/antenna-switch sequencer with register override.
// Optional sticky sequencing-error flag enabled by defining JB_PA_SEQ_ERR_EN.
module jb_rf_pa_switch_seq #(
  parameter int N_PA  = 6,
  parameter int DLY_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  jb_rf_pa_switch_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RX       = 2'd0,
    ST_SW_TO_TX = 2'd1,
    ST_TX       = 2'd2,
    ST_PA_TO_RX = 2'd3
  } state_t;

  state_t           state_reg;
  logic [DLY_W-1:0] cnt_reg;
  logic [N_PA-1:0]  en_n_reg;
  logic [N_PA-1:0]  sw_n_reg;
  logic             tx_active_reg;
  logic             busy_reg;

  // Outputs are a registered function of the current state; status flags track the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RX;
      cnt_reg       <= '0;
      en_n_reg      <= '1;
      sw_n_reg      <= '1;
      tx_active_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (bus.pa_switch_override) begin
      state_reg     <= ST_RX;
      cnt_reg       <= '0;
      en_n_reg      <= bus.pa_override_en_n;
      sw_n_reg      <= bus.pa_override_n;
      tx_active_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_RX: begin
          en_n_reg      <= '1;
          sw_n_reg      <= '1;
          tx_active_reg <= 1'b0;
          if (bus.tx_req) begin
            state_reg <= ST_SW_TO_TX;
            cnt_reg   <= bus.ant_switch_delay;
            busy_reg  <= 1'b1;
          end else begin
            busy_reg  <= 1'b0;
          end
        end
        ST_SW_TO_TX: begin
          en_n_reg <= '1;
          sw_n_reg <= ~bus.pa_chan_mask;
          if (!bus.tx_req) begin
            // PA never enabled, so the switch can return immediately.
            state_reg     <= ST_RX;
            busy_reg      <= 1'b0;
            tx_active_reg <= 1'b0;
          end else if (cnt_reg == '0) begin
            state_reg     <= ST_TX;
            busy_reg      <= 1'b0;
            tx_active_reg <= 1'b1;
          end else begin
            cnt_reg       <= cnt_reg - DLY_W'(1);
            busy_reg      <= 1'b1;
            tx_active_reg <= 1'b0;
          end
        end
        ST_TX: begin
          en_n_reg <= ~bus.pa_chan_mask;
          sw_n_reg <= ~bus.pa_chan_mask;
          if (!bus.tx_req) begin
            state_reg     <= ST_PA_TO_RX;
            cnt_reg       <= bus.ant_switch_delay;
            busy_reg      <= 1'b1;
            tx_active_reg <= 1'b0;
          end else begin
            busy_reg      <= 1'b0;
            tx_active_reg <= 1'b1;
          end
        end
        default: begin
          // PA_TO_RX: tx_req is deliberately ignored until the switch is home.
          en_n_reg      <= '1;
          sw_n_reg      <= ~bus.pa_chan_mask;
          tx_active_reg <= 1'b0;
          if (cnt_reg == '0) begin
            state_reg <= ST_RX;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg   <= cnt_reg - DLY_W'(1);
            busy_reg  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.pa_switch_en_n = en_n_reg;
  assign bus.pa_switch_n    = sw_n_reg;
  assign bus.tx_active      = tx_active_reg;
  assign bus.busy           = busy_reg;

`ifdef JB_PA_SEQ_ERR_EN
  logic seq_err_reg;
  logic err_set;

  // Late TX request during PA_TO_RX, or override yanking an active transmit.
  assign err_set = ((state_reg == ST_PA_TO_RX) && bus.tx_req) ||
                   ((state_reg == ST_TX) && bus.pa_switch_override);

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_err_reg <= 1'b0;
    end else if (err_set) begin
      seq_err_reg <= 1'b1;
    end else if (bus.err_clr) begin
      seq_err_reg <= 1'b0;
    end
  end

  assign bus.seq_err = seq_err_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.seq_err    = 1'b0;
`endif

endmodule

// File: tb/tb_jb_rf_pa_switch_seq.sv
// Directed self-checking bench for jb_rf_pa_switch_seq (seq_err expectations follow JB_PA_SEQ_ERR_EN).
module tb_jb_rf_pa_switch_seq;
  localparam int N_PA  = 6;
  localparam int DLY_W = 16;
`ifdef JB_PA_SEQ_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  jb_rf_pa_switch_seq_if #(.N_PA(N_PA), .DLY_W(DLY_W)) bus ();

  jb_rf_pa_switch_seq #(.N_PA(N_PA), .DLY_W(DLY_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx();
    int i;
    for (i = 0; i < 50 && bus.tx_active !== 1'b1; i++) tick();
    chk("wait_tx", 32'(bus.tx_active), 32'd1);
  endtask

  initial begin
    bus.tx_req             = 1'b0;
    bus.ant_switch_delay   = 16'd4;
    bus.pa_chan_mask       = 6'h3F;
    bus.pa_switch_override = 1'b0;
    bus.pa_override_en_n   = 6'h00;
    bus.pa_override_n      = 6'h00;
    bus.err_clr            = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_en_n", 32'(bus.pa_switch_en_n), 32'h3F);
    chk("rst_sw_n", 32'(bus.pa_switch_n), 32'h3F);
    chk("rst_txact", 32'(bus.tx_active), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.seq_err), 32'd0);
    rst = 1'b0;
    tick();

    // D=4, full mask: switch leads PA by 5 cycles
    bus.tx_req = 1'b1;
    tick();
    chk("d4_busy", 32'(bus.busy), 32'd1);
    chk("d4_sw_pre", 32'(bus.pa_switch_n), 32'h3F);
    tick();
    chk("d4_sw", 32'(bus.pa_switch_n), 32'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("d4_en_hold", 32'(bus.pa_switch_en_n), 32'h3F);
    end
    chk("d4_txact", 32'(bus.tx_active), 32'd1);
    chk("d4_busy_tx", 32'(bus.busy), 32'd0);
    tick();
    chk("d4_en", 32'(bus.pa_switch_en_n), 32'h00);

    bus.tx_req = 1'b0;
    tick();
    chk("d4f_busy", 32'(bus.busy), 32'd1);
    chk("d4f_txact", 32'(bus.tx_active), 32'd0);
    tick();
    chk("d4f_en", 32'(bus.pa_switch_en_n), 32'h3F);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("d4f_sw_hold", 32'(bus.pa_switch_n), 32'h00);
    end
    chk("d4f_busy_rx", 32'(bus.busy), 32'd0);
    tick();
    chk("d4f_sw", 32'(bus.pa_switch_n), 32'h3F);

    // D=0, partial mask
    bus.ant_switch_delay = 16'd0;
    bus.pa_chan_mask     = 6'h05;
    bus.tx_req           = 1'b1;
    tick();
    tick();
    chk("d0_sw", 32'(bus.pa_switch_n), 32'h3A);
    chk("d0_en_pre", 32'(bus.pa_switch_en_n), 32'h3F);
    tick();
    chk("d0_en", 32'(bus.pa_switch_en_n), 32'h3A);
    chk("d0_sw_tx", 32'(bus.pa_switch_n), 32'h3A);
    bus.tx_req = 1'b0;
    tick();
    tick();
    chk("d0_en_off", 32'(bus.pa_switch_en_n), 32'h3F);
    chk("d0_sw_hold", 32'(bus.pa_switch_n), 32'h3A);
    tick();
    chk("d0_sw_off", 32'(bus.pa_switch_n), 32'h3F);

    // D=10, abort 3 cycles into SW_TO_TX
    bus.ant_switch_delay = 16'd10;
    bus.pa_chan_mask     = 6'h3F;
    bus.tx_req           = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_en_hold", 32'(bus.pa_switch_en_n), 32'h3F);
    end
    bus.tx_req = 1'b0;
    tick();
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_en", 32'(bus.pa_switch_en_n), 32'h3F);
    tick();
    chk("ab_sw", 32'(bus.pa_switch_n), 32'h3F);

    // Override while in TX
    bus.ant_switch_delay = 16'd2;
    bus.tx_req           = 1'b1;
    tick();
    wait_tx();
    tick();
    chk("ov_pre_en", 32'(bus.pa_switch_en_n), 32'h00);
    bus.pa_switch_override = 1'b1;
    bus.pa_override_en_n   = 6'h2A;
    bus.pa_override_n      = 6'h15;
    tick();
    chk("ov_en", 32'(bus.pa_switch_en_n), 32'h2A);
    chk("ov_sw", 32'(bus.pa_switch_n), 32'h15);
    chk("ov_txact", 32'(bus.tx_active), 32'd0);
    chk("ov_busy", 32'(bus.busy), 32'd0);
    chk("ov_err", 32'(bus.seq_err), 32'(ERR_EN));
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("ov_err_clr", 32'(bus.seq_err), 32'd0);
    bus.pa_switch_override = 1'b0;
    tick();
    chk("ovr_en", 32'(bus.pa_switch_en_n), 32'h3F);
    chk("ovr_sw", 32'(bus.pa_switch_n), 32'h3F);
    chk("ovr_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("ovr_sw_tx", 32'(bus.pa_switch_n), 32'h00);

    // Reset in TX, tx_req held across release
    wait_tx();
    tick();
    rst = 1'b1;
    tick();
    chk("rtx_en", 32'(bus.pa_switch_en_n), 32'h3F);
    chk("rtx_sw", 32'(bus.pa_switch_n), 32'h3F);
    chk("rtx_txact", 32'(bus.tx_active), 32'd0);
    chk("rtx_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();
    chk("rtx_restart", 32'(bus.busy), 32'd1);
    tick();
    chk("rtx_sw_on", 32'(bus.pa_switch_n), 32'h00);
    tick(); tick();
    chk("rtx_en_hold", 32'(bus.pa_switch_en_n), 32'h3F);
    tick();
    chk("rtx_en_on", 32'(bus.pa_switch_en_n), 32'h00);

    // Late request during PA_TO_RX with D=8
    bus.ant_switch_delay = 16'd8;
    bus.tx_req           = 1'b0;
    tick();
    tick();
    chk("late_en_off", 32'(bus.pa_switch_en_n), 32'h3F);
    bus.tx_req = 1'b1;
    tick();
    chk("late_err", 32'(bus.seq_err), 32'(ERR_EN));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("late_en_hold", 32'(bus.pa_switch_en_n), 32'h3F);
    end
    bus.tx_req  = 1'b0;
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("late_clr", 32'(bus.seq_err), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("end_sw", 32'(bus.pa_switch_n), 32'h3F);
    chk("end_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
